// File: rtl/pc_sequencer.sv
// pc_sequencer -- program-counter and trap sequencer for the 16-bit
// single-cycle CPU.
//
// Holds PC and drives the next-PC select code into the external branch
// selection mux. The mux result is registered back into PC on each edge.
// Owns exception and interrupt entry/return: pending IRQ latch, EPC,
// Cause, interrupt enable and the RUN/HANDLER/HALT state machine.
//
// Optional feature macro: DOUBLE_FAULT_HALT_EN
//   defined   : an exception raised while in HANDLER halts the core
//   undefined : a nested exception is taken normally, Halted tied 0
//
// Ports:
//   Clk         in   1   system clock, rising edge
//   Rst_n       in   1   asynchronous active-low reset
//   NextPC      in  16   next-PC value from the branch selection mux
//   Stall       in   1   hold PC/state this cycle
//   BranchTaken in   1   current instruction is a taken branch
//   IsJump      in   1   current instruction is a jump
//   IsRfe       in   1   current instruction is return-from-exception
//   IllegalOp   in   1   decoder flags current instruction illegal
//   Overflow    in   1   ALU overflow on current instruction
//   IrqReq      in   1   external interrupt request (pulse or level)
//   PC          out 16   current program counter
//   PCPlus1     out 16   PC+1, mux input 0
//   EPC         out 16   exception return address, mux input 3
//   Selection   out  3   select code to branch mux
//   Cause       out  2   00 none, 01 illegal, 10 overflow, 11 irq
//   IntEnable   out  1   interrupt enable flag
//   Flush       out  1   suppress writeback this cycle
//   Halted      out  1   double-fault halt indicator
//
// Select codes: 0 PC+1, 1 branch, 2 jump, 3 EPC, 4 vec 22, 5 vec 12,
// 6 vec 200. Code 7 is never driven.

module pc_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [15:0] NextPC,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic        IsJump,
  input  logic        IsRfe,
  input  logic        IllegalOp,
  input  logic        Overflow,
  input  logic        IrqReq,
  output logic [15:0] PC,
  output logic [15:0] PCPlus1,
  output logic [15:0] EPC,
  output logic [2:0]  Selection,
  output logic [1:0]  Cause,
  output logic        IntEnable,
  output logic        Flush,
  output logic        Halted
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_HANDLER = 2'd1,
    S_HALT    = 2'd2
  } state_t;

  localparam logic [2:0] SEL_SEQ    = 3'd0;
  localparam logic [2:0] SEL_BRANCH = 3'd1;
  localparam logic [2:0] SEL_JUMP   = 3'd2;
  localparam logic [2:0] SEL_EPC    = 3'd3;
  localparam logic [2:0] SEL_ILL    = 3'd4;
  localparam logic [2:0] SEL_OVF    = 3'd5;
  localparam logic [2:0] SEL_IRQ    = 3'd6;

  state_t      state, state_nx;
  logic        irq_pending, pending_nx;
  logic [15:0] epc_nx;
  logic [1:0]  cause_nx;
  logic        ie_nx;
  logic        pc_load;
  logic        is_ctrl;
  logic        irq_take;
  logic        df_halt;

  assign PCPlus1 = PC + 16'd1;

  // Control-transfer instructions defer an interrupt: taking it would need
  // EPC to be the transfer target, which is not known here.
  assign is_ctrl  = BranchTaken | IsJump | IsRfe;
  assign irq_take = (irq_pending | IrqReq) & IntEnable & ~is_ctrl;

`ifdef DOUBLE_FAULT_HALT_EN
  assign df_halt = (state == S_HANDLER);
  assign Halted  = (state == S_HALT);
`else
  assign df_halt = 1'b0;
  assign Halted  = 1'b0;
`endif

  always_comb begin
    Selection  = SEL_SEQ;
    Flush      = 1'b0;
    state_nx   = state;
    epc_nx     = EPC;
    cause_nx   = Cause;
    ie_nx      = IntEnable;
    pending_nx = irq_pending | IrqReq;
    pc_load    = 1'b1;

    if (state == S_HALT) begin
      Flush   = 1'b1;
      pc_load = 1'b0;
    end else if (Stall) begin
      pc_load = 1'b0;
    end else if (IllegalOp || Overflow) begin
      Flush = 1'b1;
      if (df_halt) begin
        // Second fault: keep first-fault EPC/Cause for post-mortem.
        state_nx = S_HALT;
      end else begin
        Selection = IllegalOp ? SEL_ILL : SEL_OVF;
        epc_nx    = PC;
        cause_nx  = IllegalOp ? 2'b01 : 2'b10;
        ie_nx     = 1'b0;
        state_nx  = S_HANDLER;
      end
    end else if (irq_take) begin
      // Current instruction commits; resume after it.
      Selection  = SEL_IRQ;
      epc_nx     = PCPlus1;
      cause_nx   = 2'b11;
      ie_nx      = 1'b0;
      pending_nx = 1'b0;
      state_nx   = S_HANDLER;
    end else if (IsRfe) begin
      Selection = SEL_EPC;
      ie_nx     = 1'b1;
      cause_nx  = 2'b00;
      state_nx  = S_RUN;
    end else if (IsJump) begin
      Selection = SEL_JUMP;
    end else if (BranchTaken) begin
      Selection = SEL_BRANCH;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      PC          <= RESET_PC;
      EPC         <= '0;
      Cause       <= '0;
      IntEnable   <= 1'b1;
      irq_pending <= 1'b0;
      state       <= S_RUN;
    end else begin
      if (pc_load) PC <= NextPC;
      EPC         <= epc_nx;
      Cause       <= cause_nx;
      IntEnable   <= ie_nx;
      irq_pending <= pending_nx;
      state       <= state_nx;
    end
  end

endmodule
